// File: rtl/irq_ctrl.sv
// irq_ctrl: parametrised, prioritised interrupt controller with nesting.
//
// Sits between N_IRQ asynchronous interrupt lines and the CPU control unit.
// It gives each channel a mask, an edge/level mode, pending and in-service
// tracking, and nested preemption. It presents one registered request with
// its channel id and vector address. Channel 0 has the highest priority.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   irq_in      in   raw interrupt lines (asynchronous)
//   mask_wr     in   load strobe for mask_in
//   mask_in     in   new mask, 1 = masked
//   mode_wr     in   load strobe for mode_in
//   mode_in     in   new mode, 1 = level, 0 = rising edge
//   irq_ack     in   control unit accepts the presented request
//   irq_eoi     in   end of interrupt for highest-priority in-service channel
//   irq_req     out  request to the control unit
//   irq_id      out  requested channel
//   irq_vec     out  VEC_BASE + (irq_id << VEC_SHIFT)
//   pending     out  pending register
//   in_service  out  in-service register
//   mask        out  current mask register
module irq_ctrl #(
    parameter int                 N_IRQ     = 8,
    parameter int                 ID_W      = 3,
    parameter int                 VEC_W     = 16,
    parameter logic [VEC_W-1:0]   VEC_BASE  = VEC_W'(16'h0100),
    parameter int                 VEC_SHIFT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IRQ-1:0]  irq_in,
    input  logic              mask_wr,
    input  logic [N_IRQ-1:0]  mask_in,
    input  logic              mode_wr,
    input  logic [N_IRQ-1:0]  mode_in,
    input  logic              irq_ack,
    input  logic              irq_eoi,
    output logic              irq_req,
    output logic [ID_W-1:0]   irq_id,
    output logic [VEC_W-1:0]  irq_vec,
    output logic [N_IRQ-1:0]  pending,
    output logic [N_IRQ-1:0]  in_service,
    output logic [N_IRQ-1:0]  mask
);

    // Synchronizer (s1, s2) and edge history (s3) per channel.
    logic [N_IRQ-1:0] s1;
    logic [N_IRQ-1:0] s2;
    logic [N_IRQ-1:0] s3;
    logic [N_IRQ-1:0] mode;

    logic [N_IRQ-1:0] edge_det;
    logic             ack_fire;
    logic [N_IRQ-1:0] ack_vec;
    logic [N_IRQ-1:0] eoi_vec;
    logic [N_IRQ-1:0] pend_next;
    logic [N_IRQ-1:0] isr_next;
    logic [N_IRQ-1:0] cand;
    logic [ID_W-1:0]  win;
    logic             found;
    logic             blocked;
    logic             req_next;
    logic [ID_W-1:0]  id_next;

    function automatic logic [VEC_W-1:0] calc_vec(input logic [ID_W-1:0] id);
        return VEC_BASE + (VEC_W'(id) << VEC_SHIFT);
    endfunction

    always_comb begin
        edge_det = s2 & ~s3;

        // An ack only counts while a request is actually presented.
        ack_fire = irq_ack & irq_req;
        ack_vec  = ack_fire ? (N_IRQ'(1) << irq_id) : '0;

        // x & -x isolates the lowest set bit, i.e. the highest-priority
        // channel in service. EOI acts on the pre-ack in_service value.
        eoi_vec  = irq_eoi ? (in_service & (~in_service + N_IRQ'(1))) : '0;
        isr_next = (in_service & ~eoi_vec) | ack_vec;

        // Level channels follow the synchronized line. Edge channels clear on
        // ack, but an edge in the same cycle wins so no event is lost.
        pend_next = (mode & s2) | (~mode & ((pending & ~ack_vec) | edge_det));

        // Arbitration works on registered state, so a freshly set pending bit
        // or a mask change reaches irq_req one cycle later.
        cand  = pending & ~mask & ~in_service;
        win   = '0;
        found = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win   = ID_W'(i);
                found = 1'b1;
            end
        end

        // Nesting: any in-service channel of higher priority holds the winner off.
        blocked  = (in_service & ((N_IRQ'(1) << win) - N_IRQ'(1))) != '0;

        // The cycle after an ack always shows no request.
        req_next = found & ~blocked & ~ack_fire;
        id_next  = req_next ? win : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            mask       <= '1;
            mode       <= '0;
            pending    <= '0;
            in_service <= '0;
            irq_req    <= 1'b0;
            irq_id     <= '0;
            irq_vec    <= VEC_BASE;
        end else begin
            s1         <= irq_in;
            s2         <= s1;
            s3         <= s2;
            pending    <= pend_next;
            in_service <= isr_next;
            irq_req    <= req_next;
            irq_id     <= id_next;
            irq_vec    <= calc_vec(id_next);
            if (mask_wr) begin
                mask <= mask_in;
            end
            if (mode_wr) begin
                mode <= mode_in;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  irq_in;
    logic          mask_wr;
    logic [N-1:0]  mask_in;
    logic          mode_wr;
    logic [N-1:0]  mode_in;
    logic          irq_ack;
    logic          irq_eoi;
    logic          irq_req;
    logic [2:0]    irq_id;
    logic [15:0]   irq_vec;
    logic [N-1:0]  pending;
    logic [N-1:0]  in_service;
    logic [N-1:0]  mask;

    int vectors     = 0;
    int miscompares = 0;

    irq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_wr    (mask_wr),
        .mask_in    (mask_in),
        .mode_wr    (mode_wr),
        .mode_in    (mode_in),
        .irq_ack    (irq_ack),
        .irq_eoi    (irq_eoi),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_vec    (irq_vec),
        .pending    (pending),
        .in_service (in_service),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    // Reference model: per-channel booleans and a history of sampled lines.
    bit m_line [3][N];   // [0] sampled last edge, [1] two edges ago, [2] three
    bit m_pend [N];
    bit m_isr  [N];
    bit m_mask [N];
    bit m_mode [N];
    bit m_req;
    int m_id;

    function automatic logic [7:0] pack(input bit v [N]);
        logic [7:0] r;
        for (int c = 0; c < N; c++) r[c] = v[c];
        return r;
    endfunction

    task automatic model_edge();
        bit ack;
        int ach;
        bit n_pend [N];
        bit n_isr  [N];
        int best;
        bit busy_above;
        if (reset) begin
            for (int c = 0; c < N; c++) begin
                m_pend[c] = 0; m_isr[c] = 0; m_mask[c] = 1; m_mode[c] = 0;
                m_line[0][c] = 0; m_line[1][c] = 0; m_line[2][c] = 0;
            end
            m_req = 0;
            m_id  = 0;
            return;
        end
        ack = irq_ack && m_req;
        ach = m_id;
        n_isr = m_isr;
        if (irq_eoi) begin
            for (int c = 0; c < N; c++) begin
                if (m_isr[c]) begin
                    n_isr[c] = 0;
                    break;
                end
            end
        end
        if (ack) n_isr[ach] = 1;
        for (int c = 0; c < N; c++) begin
            if (m_mode[c]) begin
                n_pend[c] = m_line[1][c];
            end else begin
                n_pend[c] = m_pend[c];
                if (ack && ach == c) n_pend[c] = 0;
                if (m_line[1][c] && !m_line[2][c]) n_pend[c] = 1;
            end
        end
        best = -1;
        for (int c = N - 1; c >= 0; c--)
            if (m_pend[c] && !m_mask[c] && !m_isr[c]) best = c;
        busy_above = 0;
        for (int c = 0; c < best; c++)
            if (m_isr[c]) busy_above = 1;
        m_req = (best >= 0) && !busy_above && !ack;
        m_id  = m_req ? best : 0;
        m_pend = n_pend;
        m_isr  = n_isr;
        for (int c = 0; c < N; c++) begin
            if (mask_wr) m_mask[c] = mask_in[c];
            if (mode_wr) m_mode[c] = mode_in[c];
            m_line[2][c] = m_line[1][c];
            m_line[1][c] = m_line[0][c];
            m_line[0][c] = irq_in[c];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_pending", 32'(pending), 32'(pack(m_pend)));
        chk("model_in_service", 32'(in_service), 32'(pack(m_isr)));
        chk("model_mask", 32'(mask), 32'(pack(m_mask)));
        chk("model_req", 32'(irq_req), 32'(m_req));
        if (m_req) begin
            chk("model_id", 32'(irq_id), 32'(m_id));
            chk("model_vec", 32'(irq_vec), 32'h100 + 32'(m_id) * 4);
        end
    endtask

    task automatic pulse(input logic [N-1:0] lines);
        irq_in = lines;
        tick();
        irq_in = '0;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic do_eoi();
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_in = '0; mask_wr = 1'b0; mask_in = '0;
        mode_wr = 1'b0; mode_in = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
        tick(); tick();
        chk("rst_req", 32'(irq_req), 0);
        chk("rst_id", 32'(irq_id), 0);
        chk("rst_vec", 32'(irq_vec), 32'h0100);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_in_service", 32'(in_service), 0);
        chk("rst_mask", 32'(mask), 32'hFF);
        reset = 1'b0;

        mask_wr = 1'b1; mask_in = '0; tick(); mask_wr = 1'b0;
        chk("unmask", 32'(mask), 0);

        // Basic edge request on channel 5
        pulse(8'h20); tick(); tick();
        chk("p5_pending", 32'(pending), 32'h20);
        chk("p5_no_req_yet", 32'(irq_req), 0);
        tick();
        chk("p5_req", 32'(irq_req), 1);
        chk("p5_id", 32'(irq_id), 5);
        chk("p5_vec", 32'(irq_vec), 32'h0114);
        do_ack();
        chk("p5_ack_isr", 32'(in_service), 32'h20);
        chk("p5_ack_pend", 32'(pending), 0);
        chk("p5_ack_req", 32'(irq_req), 0);

        // Nesting: channel 2 preempts 5, channel 6 waits for both EOIs
        pulse(8'h04); tick(); tick(); tick();
        chk("n2_req", 32'(irq_req), 1);
        chk("n2_id", 32'(irq_id), 2);
        chk("n2_vec", 32'(irq_vec), 32'h0108);
        do_ack();
        chk("n2_isr", 32'(in_service), 32'h24);
        pulse(8'h40); tick(); tick(); tick();
        chk("n6_pend", 32'(pending), 32'h40);
        chk("n6_blocked", 32'(irq_req), 0);
        do_eoi();
        chk("eoi1_isr", 32'(in_service), 32'h20);
        tick();
        chk("n6_still_blocked", 32'(irq_req), 0);
        do_eoi();
        chk("eoi2_isr", 32'(in_service), 0);
        tick();
        chk("n6_req", 32'(irq_req), 1);
        chk("n6_id", 32'(irq_id), 6);
        do_ack(); do_eoi();
        chk("n6_done", 32'(in_service), 0);

        // Mask blocks requesting but not recording
        mask_wr = 1'b1; mask_in = 8'h08; tick(); mask_wr = 1'b0;
        pulse(8'h08); tick(); tick(); tick();
        chk("m3_pend", 32'(pending), 32'h08);
        chk("m3_masked", 32'(irq_req), 0);
        mask_wr = 1'b1; mask_in = 8'h00; tick(); mask_wr = 1'b0;
        tick();
        chk("m3_req", 32'(irq_req), 1);
        chk("m3_id", 32'(irq_id), 3);
        do_ack(); do_eoi();

        // Level mode on channel 1 with the line held
        mode_wr = 1'b1; mode_in = 8'h02; tick(); mode_wr = 1'b0;
        irq_in = 8'h02;
        tick(); tick(); tick();
        chk("l1_pend", 32'(pending[1]), 1);
        tick();
        chk("l1_req", 32'(irq_req), 1);
        chk("l1_id", 32'(irq_id), 1);
        chk("l1_vec", 32'(irq_vec), 32'h0104);
        do_ack();
        chk("l1_pend_after_ack", 32'(pending[1]), 1);
        chk("l1_isr", 32'(in_service), 32'h02);
        tick(); tick();
        chk("l1_no_rereq", 32'(irq_req), 0);
        do_eoi(); tick();
        chk("l1_rereq", 32'(irq_req), 1);
        chk("l1_rereq_id", 32'(irq_id), 1);
        do_ack();
        irq_in = '0;
        tick(); tick();
        chk("l1_pend_lag", 32'(pending[1]), 1);
        tick();
        chk("l1_pend_drop", 32'(pending[1]), 0);
        do_eoi();
        mode_wr = 1'b1; mode_in = 8'h00; tick(); mode_wr = 1'b0;

        // New edge on channel 4 in the very cycle it is acked
        pulse(8'h10); tick();
        irq_in = 8'h10; tick(); irq_in = '0;
        chk("s4_pend", 32'(pending), 32'h10);
        tick();
        chk("s4_req", 32'(irq_req), 1);
        chk("s4_id", 32'(irq_id), 4);
        do_ack();
        chk("s4_pend_kept", 32'(pending[4]), 1);
        chk("s4_isr", 32'(in_service), 32'h10);
        do_eoi(); tick();
        chk("s4_req_again", 32'(irq_req), 1);

        // Reset during an active request and ack
        reset = 1'b1; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("mid_rst_req", 32'(irq_req), 0);
        chk("mid_rst_id", 32'(irq_id), 0);
        chk("mid_rst_vec", 32'(irq_vec), 32'h0100);
        chk("mid_rst_pending", 32'(pending), 0);
        chk("mid_rst_isr", 32'(in_service), 0);
        chk("mid_rst_mask", 32'(mask), 32'hFF);
        reset = 1'b0;
        mask_wr = 1'b1; mask_in = '0; tick(); mask_wr = 1'b0;

        // Randomized traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            irq_in  = 8'($urandom);
            irq_ack = ($urandom_range(0, 99) < 40);
            irq_eoi = ($urandom_range(0, 99) < 20);
            mask_wr = ($urandom_range(0, 99) < 5);
            mask_in = 8'($urandom) & 8'($urandom);
            mode_wr = ($urandom_range(0, 99) < 5);
            mode_in = 8'($urandom);
            reset   = ($urandom_range(0, 999) < 5);
            tick();
        end
        reset = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0;
        mask_wr = 1'b0; mode_wr = 1'b0; irq_in = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
